// File: rtl/pe_code_decoder.sv
// Priority-code decoder: buffers 2-bit codes in a FIFO, emits one-hot
// request words with a minimum hold time and a valid/ack handshake.
module pe_code_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD       = 3,
  parameter int ZCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [2:0]        dec_out,
  output logic              dec_valid,
  input  logic              dec_ack,
  output logic              busy,
  output logic [ZCNT_W-1:0] zero_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [1:0]    head;
  logic [2:0]    onehot;
  logic [0:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          hold_last;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);

  assign code_ready = !fifo_full;
  assign push       = code_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign head       = mem[rptr[AW-1:0]];
  assign hold_last  = (hold_cnt == HOLD_LAST);
  assign busy       = !fifo_empty || (state != IDLE);

  always_comb begin
    onehot = 3'b000;
    unique case (1'b1)
      head == 2'd1: onehot = 3'b001;
      head == 2'd2: onehot = 3'b010;
      head == 2'd3: onehot = 3'b100;
      default:      onehot = 3'b000;
    endcase
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= code_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      dec_out   <= 3'b000;
      dec_valid <= 1'b0;
      zero_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (head == 2'd0) begin
              if (zero_cnt != '1) zero_cnt <= zero_cnt + 1'b1;
            end else begin
              state     <= DRIVE;
              dec_out   <= onehot;
              dec_valid <= 1'b1;
              hold_cnt  <= '0;
            end
          end
        end
        DRIVE: begin
          if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
          if (hold_last && dec_ack) begin
            state     <= IDLE;
            dec_out   <= 3'b000;
            dec_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_code_decoder.sv
// Directed, table-driven bench for pe_code_decoder.
// A second instance with a 2-bit zero counter covers saturation.
module tb_pe_code_decoder;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] code_in = 2'd0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [2:0] dec_out;
  logic       dec_valid;
  logic       dec_ack = 1'b1;
  logic       busy;
  logic [7:0] zero_cnt;

  logic [1:0] code_in2 = 2'd0;
  logic       code_valid2 = 1'b0;
  logic       code_ready2;
  logic [2:0] dec_out2;
  logic       dec_valid2;
  logic       dec_ack2 = 1'b1;
  logic       busy2;
  logic [1:0] zero_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_code_decoder #(.FIFO_DEPTH(4), .HOLD(HOLD), .ZCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .dec_out(dec_out), .dec_valid(dec_valid), .dec_ack(dec_ack),
    .busy(busy), .zero_cnt(zero_cnt)
  );

  pe_code_decoder #(.FIFO_DEPTH(4), .HOLD(HOLD), .ZCNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in2), .code_valid(code_valid2), .code_ready(code_ready2),
    .dec_out(dec_out2), .dec_valid(dec_valid2), .dec_ack(dec_ack2),
    .busy(busy2), .zero_cnt(zero_cnt2)
  );

  typedef struct {
    logic [1:0] code;
    logic [2:0] exp_out;
    logic [7:0] exp_zcnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [1:0] c, input string nm);
    code_in = c;
    code_valid = 1'b1;
    chk({nm, "_ready"}, code_ready, 1);
    step();
    code_valid = 1'b0;
  endtask

  // Waits for the next word, checks value, gap and hold length.
  task automatic wait_word(input logic [2:0] exp, input int gap,
                           input int hi, input string nm);
    int n;
    int c;
    bit stable;
    n = 0;
    while (!dec_valid && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_valid"}, dec_valid, 1);
    chk({nm, "_out"}, dec_out, exp);
    if (gap >= 0) chk({nm, "_gap"}, n, gap);
    c = 0;
    stable = 1'b1;
    while (dec_valid && c < 40) begin
      if (dec_out !== exp) stable = 1'b0;
      step();
      c++;
    end
    chk({nm, "_stable"}, stable, 1);
    if (hi >= 0) chk({nm, "_hold"}, c, hi);
    chk({nm, "_off"}, dec_out, 0);
  endtask

  initial begin
    vec_t vt[6];
    bit seen;
    vt[0] = '{2'd1, 3'b001, 8'd0};
    vt[1] = '{2'd2, 3'b010, 8'd0};
    vt[2] = '{2'd3, 3'b100, 8'd0};
    vt[3] = '{2'd0, 3'b000, 8'd1};
    vt[4] = '{2'd2, 3'b010, 8'd1};
    vt[5] = '{2'd0, 3'b000, 8'd2};

    #12;
    chk("rst_valid", dec_valid, 0);
    chk("rst_out", dec_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zcnt", zero_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("rel_ready", code_ready, 1);
    chk("rel_busy", busy, 0);

    // Single decodes with dec_ack held high
    for (int i = 0; i < 6; i++) begin
      push1(vt[i].code, $sformatf("v%0d", i));
      if (vt[i].code == 2'd0) begin
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (dec_valid) seen = 1'b1;
          step();
        end
        chk($sformatf("v%0d_novalid", i), seen, 0);
      end else begin
        wait_word(vt[i].exp_out, 1, HOLD, $sformatf("v%0d", i));
      end
      chk($sformatf("v%0d_zcnt", i), zero_cnt, vt[i].exp_zcnt);
    end

    // Reset mid-DRIVE with a code still queued
    dec_ack = 1'b0;
    push1(2'd2, "mr_a");
    push1(2'd3, "mr_b");
    chk("mr_valid_pre", dec_valid, 1);
    chk("mr_out_pre", dec_out, 3'b010);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_valid", dec_valid, 0);
    chk("mr_out", dec_out, 0);
    chk("mr_busy", busy, 0);
    chk("mr_zcnt", zero_cnt, 0);
    #2 rst_n = 1'b1;
    dec_ack = 1'b1;
    step();
    chk("mr_ready", code_ready, 1);
    step();
    step();
    chk("mr_flushed", busy, 0);
    chk("mr_quiet", dec_valid, 0);

    // Zero codes back-to-back then a real code
    code_valid = 1'b1;
    code_in = 2'd0; step();
    code_in = 2'd0; step();
    code_in = 2'd2; step();
    code_valid = 1'b0;
    chk("z_novalid", dec_valid, 0);
    wait_word(3'b010, 1, HOLD, "z_w");
    chk("z_zcnt", zero_cnt, 2);

    // Ack stall
    dec_ack = 1'b0;
    push1(2'd1, "st");
    step();
    seen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!dec_valid || dec_out !== 3'b001) seen = 1'b0;
      step();
    end
    chk("st_stable", seen, 1);
    chk("st_still", dec_valid, 1);
    dec_ack = 1'b1;
    step();
    chk("st_release", dec_valid, 0);
    chk("st_rel_out", dec_out, 0);
    step();

    // Full FIFO with stalled consumer
    dec_ack = 1'b0;
    push1(2'd1, "ff0");
    push1(2'd2, "ff1");
    push1(2'd3, "ff2");
    push1(2'd1, "ff3");
    push1(2'd2, "ff4");
    chk("ff_full", code_ready, 0);
    code_in = 2'd3;
    code_valid = 1'b1;
    step();
    step();
    code_valid = 1'b0;
    chk("ff_still_full", code_ready, 0);
    chk("ff_out0", dec_out, 3'b001);
    dec_ack = 1'b1;
    wait_word(3'b001, 0, -1, "ff_d0");
    wait_word(3'b010, 1, HOLD, "ff_d1");
    wait_word(3'b100, 1, HOLD, "ff_d2");
    wait_word(3'b001, 1, HOLD, "ff_d3");
    wait_word(3'b010, 1, HOLD, "ff_d4");
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (dec_valid) seen = 1'b1;
      step();
    end
    chk("ff_no_sixth", seen, 0);
    chk("ff_idle", busy, 0);

    // Push on the IDLE pop edge with two entries queued
    dec_ack = 1'b0;
    push1(2'd1, "sp0");
    push1(2'd2, "sp1");
    push1(2'd3, "sp2");
    step();
    dec_ack = 1'b1;
    step();
    chk("sp_exit", dec_valid, 0);
    chk("sp_busy", busy, 1);
    code_in = 2'd1;
    code_valid = 1'b1;
    chk("sp_ready", code_ready, 1);
    step();
    code_valid = 1'b0;
    wait_word(3'b010, 0, HOLD, "sp_w1");
    wait_word(3'b100, 1, HOLD, "sp_w2");
    wait_word(3'b001, 1, HOLD, "sp_w3");
    step();
    step();
    chk("sp_drained", busy, 0);
    chk("sp_quiet", dec_valid, 0);

    // Zero counter saturation on the narrow instance
    code_in2 = 2'd0;
    code_valid2 = 1'b1;
    for (int k = 0; k < 5; k++) step();
    code_valid2 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("sat_zcnt", zero_cnt2, 2'd3);
    chk("sat_novalid", dec_valid2, 0);
    chk("sat_idle", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
